// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller: NS/EW sequencing with optional left arrows,
// all-red clearance, yellow-first emergency preemption and a flashing night mode.
module traffic_intersection_ctrl #(
  parameter int T_LEFT   = 5,
  parameter int T_GREEN  = 9,
  parameter int T_YELLOW = 3,
  parameter int T_CLEAR  = 1,
  parameter int T_FLASH  = 4,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       flash_req,
  output logic [3:0] ns_lights,
  output logic [3:0] ew_lights,
  output logic [3:0] phase,
  output logic       preempt_active
);

  typedef enum logic [3:0] {
    NS_LEFT  = 4'd0,  NS_GREEN = 4'd1, NS_YEL = 4'd2, CLR_A = 4'd3,
    EW_LEFT  = 4'd4,  EW_GREEN = 4'd5, EW_YEL = 4'd6, CLR_B = 4'd7,
    PRE_YEL  = 4'd8,  PREEMPT  = 4'd9, FLASH  = 4'd10
  } state_t;

  localparam int T_MAX_A = (T_LEFT > T_GREEN) ? T_LEFT : T_GREEN;
  localparam int T_MAX_B = (T_YELLOW > T_CLEAR) ? T_YELLOW : T_CLEAR;
  localparam int T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX   = (T_MAX_C > T_FLASH) ? T_MAX_C : T_FLASH;

  if ((T_MAX - 1) >= (2 ** CW)) begin : g_cw_check
    $error("CW too narrow to hold the longest phase count");
  end

  localparam state_t NS_START = state_t'((T_LEFT == 0) ? 4'd1 : 4'd0);
  localparam state_t EW_START = state_t'((T_LEFT == 0) ? 4'd5 : 4'd4);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          flash_ph_r, flash_ph_s;
  logic          saved_ns_r, saved_ns_s;   // 1: resume NS after preemption, 0: resume EW
  logic          emg_pend_r, emg_pend_s;   // emergency seen during a yellow phase
  logic          last_s, ns_side_s;

  function automatic logic [CW-1:0] last_of(input state_t s);
    case (s)
      NS_LEFT, EW_LEFT:          last_of = CW'(T_LEFT - 1);
      NS_GREEN, EW_GREEN:        last_of = CW'(T_GREEN - 1);
      NS_YEL, EW_YEL, PRE_YEL:   last_of = CW'(T_YELLOW - 1);
      FLASH:                     last_of = CW'(T_FLASH - 1);
      default:                   last_of = CW'(T_CLEAR - 1);
    endcase
  endfunction

  function automatic state_t next_normal(input state_t s);
    case (s)
      NS_LEFT:  next_normal = NS_GREEN;
      NS_GREEN: next_normal = NS_YEL;
      NS_YEL:   next_normal = CLR_A;
      EW_LEFT:  next_normal = EW_GREEN;
      EW_GREEN: next_normal = EW_YEL;
      EW_YEL:   next_normal = CLR_B;
      default:  next_normal = NS_START;
    endcase
  endfunction

  // State, phase counter, flash phase and preemption bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= NS_START;
      cnt_r      <= '0;
      flash_ph_r <= 1'b0;
      saved_ns_r <= 1'b0;
      emg_pend_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      flash_ph_r <= flash_ph_s;
      saved_ns_r <= saved_ns_s;
      emg_pend_r <= emg_pend_s;
    end
  end

  // Next-state logic: emergency outranks both normal advance and flash requests
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + CW'(1);
    flash_ph_s = flash_ph_r;
    saved_ns_s = saved_ns_r;
    emg_pend_s = emg_pend_r;
    last_s     = (cnt_r == last_of(state_r));
    ns_side_s  = (state_r == NS_LEFT) || (state_r == NS_GREEN) ||
                 (state_r == NS_YEL)  || (state_r == CLR_A);
    case (state_r)
      NS_LEFT, NS_GREEN, EW_LEFT, EW_GREEN: begin
        if (emergency) begin
          state_s    = PRE_YEL;
          cnt_s      = '0;
          saved_ns_s = !ns_side_s;
        end else if (last_s) begin
          state_s = next_normal(state_r);
          cnt_s   = '0;
        end else begin
          state_s = state_r;
        end
      end
      NS_YEL, EW_YEL: begin
        if (emergency) begin
          emg_pend_s = 1'b1;
          saved_ns_s = !ns_side_s;
        end else begin
          emg_pend_s = emg_pend_r;
        end
        if (last_s) begin
          state_s    = (emergency || emg_pend_r) ? PREEMPT : next_normal(state_r);
          cnt_s      = '0;
          emg_pend_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      CLR_A, CLR_B: begin
        if (emergency) begin
          state_s    = PREEMPT;
          cnt_s      = '0;
          saved_ns_s = !ns_side_s;
        end else if (last_s) begin
          cnt_s = '0;
          if (flash_req) begin
            state_s    = FLASH;
            flash_ph_s = 1'b1;
          end else begin
            state_s = (state_r == CLR_A) ? EW_START : NS_START;
          end
        end else begin
          state_s = state_r;
        end
      end
      PRE_YEL: begin
        if (last_s) begin
          state_s = PREEMPT;
          cnt_s   = '0;
        end else begin
          state_s = state_r;
        end
      end
      PREEMPT: begin
        // cnt only runs once emergency has dropped; any re-assertion restarts the hold
        if (emergency) begin
          cnt_s = '0;
        end else if (last_s) begin
          state_s = saved_ns_r ? NS_START : EW_START;
          cnt_s   = '0;
        end else begin
          state_s = state_r;
        end
      end
      FLASH: begin
        if (emergency) begin
          state_s    = PREEMPT;
          cnt_s      = '0;
          saved_ns_s = 1'b1;
        end else if (!flash_req) begin
          state_s = CLR_B;
          cnt_s   = '0;
        end else if (last_s) begin
          cnt_s      = '0;
          flash_ph_s = !flash_ph_r;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = NS_START;
        cnt_s   = '0;
      end
    endcase
  end

  // Light head decode from the registered state
  always_comb begin
    ns_lights = 4'b0001;
    ew_lights = 4'b0001;
    case (state_r)
      NS_LEFT:  ns_lights = 4'b1001;
      NS_GREEN: ns_lights = 4'b0100;
      NS_YEL:   ns_lights = 4'b0010;
      EW_LEFT:  ew_lights = 4'b1001;
      EW_GREEN: ew_lights = 4'b0100;
      EW_YEL:   ew_lights = 4'b0010;
      PRE_YEL: begin
        if (saved_ns_r) begin
          ew_lights = 4'b0010;
        end else begin
          ns_lights = 4'b0010;
        end
      end
      FLASH: begin
        ns_lights = flash_ph_r ? 4'b0010 : 4'b0000;
        ew_lights = flash_ph_r ? 4'b0001 : 4'b0000;
      end
      default: begin
        ns_lights = 4'b0001;
        ew_lights = 4'b0001;
      end
    endcase
  end

  assign phase          = state_r;
  assign preempt_active = (state_r == PRE_YEL) || (state_r == PREEMPT);

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed test-plan scenarios plus randomized stimulus, checked against a
// table-driven reference model for the default and the no-left-turn configurations.
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst, emergency, flash_req;
  logic [3:0] ns1, ew1, ph1, ns2, ew2, ph2;
  logic       pa1, pa2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state per instance (0: defaults, 1: T_LEFT=0, T_GREEN=2)
  int m_st[2];
  int m_t[2];
  bit m_ph[2];
  bit m_dirns[2];
  bit m_pend[2];
  int tl[2] = '{5, 0};
  int tg[2] = '{9, 2};
  localparam int TY = 3;
  localparam int TC = 1;
  localparam int TF = 4;

  traffic_intersection_ctrl u_dut (
    .clk(clk), .rst(rst), .emergency(emergency), .flash_req(flash_req),
    .ns_lights(ns1), .ew_lights(ew1), .phase(ph1), .preempt_active(pa1)
  );

  traffic_intersection_ctrl #(.T_LEFT(0), .T_GREEN(2)) u_dut2 (
    .clk(clk), .rst(rst), .emergency(emergency), .flash_req(flash_req),
    .ns_lights(ns2), .ew_lights(ew2), .phase(ph2), .preempt_active(pa2)
  );

  always #5 clk = ~clk;

  function automatic int dur(int i, int s);
    case (s)
      0, 4:    return tl[i];
      1, 5:    return tg[i];
      2, 6, 8: return TY;
      10:      return TF;
      default: return TC;
    endcase
  endfunction

  function automatic int ns_start(int i);
    return (tl[i] > 0) ? 0 : 1;
  endfunction

  function automatic int ew_start(int i);
    return (tl[i] > 0) ? 4 : 5;
  endfunction

  function automatic logic [3:0] exp_ns(int i);
    case (m_st[i])
      0:       return 4'b1001;
      1:       return 4'b0100;
      2:       return 4'b0010;
      8:       return m_dirns[i] ? 4'b0001 : 4'b0010;
      10:      return m_ph[i] ? 4'b0010 : 4'b0000;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] exp_ew(int i);
    case (m_st[i])
      4:       return 4'b1001;
      5:       return 4'b0100;
      6:       return 4'b0010;
      8:       return m_dirns[i] ? 4'b0010 : 4'b0001;
      10:      return m_ph[i] ? 4'b0001 : 4'b0000;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit e, input bit f);
    for (int i = 0; i < 2; i++) begin
      bit done;
      done = (m_t[i] + 1 == dur(i, m_st[i]));
      if (r) begin
        m_st[i] = ns_start(i); m_t[i] = 0; m_ph[i] = 0; m_dirns[i] = 0; m_pend[i] = 0;
      end else begin
        case (m_st[i])
          0, 1, 4, 5: begin
            if (e) begin
              m_dirns[i] = (m_st[i] >= 4); m_st[i] = 8; m_t[i] = 0;
            end else if (done) begin
              m_st[i] = (m_st[i] == 0) ? 1 : (m_st[i] == 1) ? 2 : (m_st[i] == 4) ? 5 : 6;
              m_t[i] = 0;
            end else m_t[i]++;
          end
          2, 6: begin
            if (e) begin m_pend[i] = 1; m_dirns[i] = (m_st[i] == 6); end
            if (done) begin
              m_st[i] = m_pend[i] ? 9 : m_st[i] + 1; m_pend[i] = 0; m_t[i] = 0;
            end else m_t[i]++;
          end
          3, 7: begin
            if (e) begin
              m_dirns[i] = (m_st[i] == 7); m_st[i] = 9; m_t[i] = 0;
            end else if (done) begin
              m_t[i] = 0;
              if (f) begin m_st[i] = 10; m_ph[i] = 1; end
              else m_st[i] = (m_st[i] == 3) ? ew_start(i) : ns_start(i);
            end else m_t[i]++;
          end
          8: begin
            if (done) begin m_st[i] = 9; m_t[i] = 0; end else m_t[i]++;
          end
          9: begin
            if (e) m_t[i] = 0;
            else if (done) begin
              m_st[i] = m_dirns[i] ? ns_start(i) : ew_start(i); m_t[i] = 0;
            end else m_t[i]++;
          end
          default: begin
            if (e) begin m_dirns[i] = 1; m_st[i] = 9; m_t[i] = 0; end
            else if (!f) begin m_st[i] = 7; m_t[i] = 0; end
            else if (done) begin m_t[i] = 0; m_ph[i] = !m_ph[i]; end
            else m_t[i]++;
          end
        endcase
      end
    end
  endtask

  task automatic chk(input logic [3:0] obs, input logic [3:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_check();
    chk(ns1, exp_ns(0), "m1_ns");
    chk(ew1, exp_ew(0), "m1_ew");
    chk(ph1, 4'(m_st[0]), "m1_phase");
    chk({3'b000, pa1}, {3'b000, (m_st[0] == 8) || (m_st[0] == 9)}, "m1_preempt");
    chk(ns2, exp_ns(1), "m2_ns");
    chk(ew2, exp_ew(1), "m2_ew");
    chk(ph2, 4'(m_st[1]), "m2_phase");
    chk({3'b000, pa2}, {3'b000, (m_st[1] == 8) || (m_st[1] == 9)}, "m2_preempt");
    chk({3'b000, (ns2 == 4'b1001) || (ew2 == 4'b1001)}, 4'b0000, "noleft_arrow");
  endtask

  task automatic cycle(input bit r, input bit e, input bit f);
    rst = r; emergency = e; flash_req = f;
    @(posedge clk);
    model_step(r, e, f);
    #1;
    if (r) cyc = 0; else cyc++;
    model_check();
  endtask

  initial begin
    bit r, e, f;
    rst = 1'b1; emergency = 1'b0; flash_req = 1'b0;

    // reset release, no requests
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk(ns1, 4'b1001, "rst_ns"); chk(ew1, 4'b0001, "rst_ew");
    chk(ph1, 4'd0, "rst_phase"); chk({3'b000, pa1}, 4'b0000, "rst_preempt");
    repeat (37) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (cyc <= 4) chk(ns1, 4'b1001, "s1_ns_left");
      else if (cyc <= 13) chk(ns1, 4'b0100, "s1_ns_green");
      else if (cyc <= 16) chk(ns1, 4'b0010, "s1_ns_yel");
      else if (cyc == 17) begin chk(ns1, 4'b0001, "s1_clr_ns"); chk(ew1, 4'b0001, "s1_clr_ew"); end
      else if (cyc <= 22) chk(ew1, 4'b1001, "s1_ew_left");
      else if (cyc == 36) chk(ph1, 4'd0, "s1_wrap");
      else chk(ph1, 4'(m_st[0]), "s1_phase");
      if (cyc <= 1) chk(ph2, 4'd1, "s5_ns_green");
      else if (cyc <= 4) chk(ph2, 4'd2, "s5_ns_yel");
      else if (cyc == 5) chk(ph2, 4'd3, "s5_clr");
      else if (cyc == 6) chk(ph2, 4'd5, "s5_ew_green");
      else chk(ph2, 4'(m_st[1]), "s5_phase");
    end

    // emergency held cycles 7..20 from NS_GREEN
    cycle(1'b1, 1'b0, 1'b0);
    repeat (24) begin
      cycle(1'b0, (cyc >= 7) && (cyc <= 20), 1'b0);
      if (cyc >= 8 && cyc <= 10) chk(ns1, 4'b0010, "s2_pre_yel");
      if (cyc >= 11 && cyc <= 21) begin chk(ns1, 4'b0001, "s2_red_ns"); chk(ew1, 4'b0001, "s2_red_ew"); end
      if (cyc == 22) chk(ew1, 4'b1001, "s2_resume_ew_left");
      chk({3'b000, pa1}, {3'b000, (cyc >= 8) && (cyc <= 21)}, "s2_preempt_active");
    end

    // emergency pulse during NS_YEL
    cycle(1'b1, 1'b0, 1'b0);
    repeat (20) begin
      cycle(1'b0, cyc == 15, 1'b0);
      if (cyc == 16) chk(ph1, 4'd2, "s3_yel_on_schedule");
      if (cyc == 17) chk(ph1, 4'd9, "s3_preempt");
      if (cyc == 18) chk(ew1, 4'b1001, "s3_resume_ew_left");
    end

    // flash mode requested from cycle 2, dropped at cycle 26
    cycle(1'b1, 1'b0, 1'b0);
    repeat (29) begin
      cycle(1'b0, 1'b0, (cyc >= 2) && (cyc <= 25));
      if (cyc >= 18 && cyc <= 21) begin chk(ns1, 4'b0010, "s4_flash_on_ns"); chk(ew1, 4'b0001, "s4_flash_on_ew"); end
      if (cyc >= 22 && cyc <= 25) begin chk(ns1, 4'b0000, "s4_flash_off_ns"); chk(ew1, 4'b0000, "s4_flash_off_ew"); end
      if (cyc == 27) chk(ph1, 4'd7, "s4_clr_b");
      if (cyc == 28) chk(ns1, 4'b1001, "s4_ns_left");
    end

    // reset while in PREEMPT with emergency still high
    cycle(1'b1, 1'b0, 1'b0);
    repeat (12) cycle(1'b0, cyc >= 3, 1'b0);
    chk(ph1, 4'd9, "s6_in_preempt");
    cycle(1'b1, 1'b1, 1'b0);
    chk(ns1, 4'b1001, "s6_rst_ns"); chk(ph1, 4'd0, "s6_rst_phase"); chk({3'b000, pa1}, 4'b0000, "s6_rst_preempt");
    cycle(1'b0, 1'b1, 1'b0);
    chk({3'b000, pa1}, 4'b0001, "s6_repreempt");

    // randomized stimulus against the model
    e = 1'b0; f = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(39) == 0) e = !e;
      if ($urandom_range(89) == 0) f = !f;
      r = ($urandom_range(599) == 0);
      cycle(r, e, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
